// File: rtl/alarm_clock_ctrl_if.sv
// Signal bundle between the button/prescaler front end, the time counters and
// alarm_clock_ctrl. The front end and counters drive the master side; the controller is the slave.
interface alarm_clock_ctrl_if;
    // Inputs are levels or one-cycle pulses sampled every clock. Outputs are registered
    // one-cycle strobes or levels; there is no back-pressure.
    logic       Tick;
    logic       Mode_Btn;
    logic       Adv_Btn;
    logic       Alarm_Sw;
    logic [5:0] Time_Sec;
    logic [5:0] Time_Min;
    logic [4:0] Time_Hr;
    logic       Sec_Inc;
    logic       Min_Inc;
    logic       Hr_Inc;
    logic       Sec_Clr;
    logic [5:0] Alarm_Min;
    logic [4:0] Alarm_Hr;
    logic [2:0] Mode;
    logic       Ring;
    logic       Blink;

    modport master (
        output Tick, Mode_Btn, Adv_Btn, Alarm_Sw, Time_Sec, Time_Min, Time_Hr,
        input  Sec_Inc, Min_Inc, Hr_Inc, Sec_Clr, Alarm_Min, Alarm_Hr, Mode, Ring, Blink
    );

    modport slave (
        input  Tick, Mode_Btn, Adv_Btn, Alarm_Sw, Time_Sec, Time_Min, Time_Hr,
        output Sec_Inc, Min_Inc, Hr_Inc, Sec_Clr, Alarm_Min, Alarm_Hr, Mode, Ring, Blink
    );
endinterface

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: tick/button strobes to the time counters, alarm setpoint and ring.
// Optional snooze is built when ALARM_CLOCK_SNOOZE_EN is defined.
module alarm_clock_ctrl #(
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_MIN    = 5,
    parameter int ALARM_HR_RST  = 6,
    parameter int ALARM_MIN_RST = 0
) (
    input logic               Clk,
    input logic               Clr,
    alarm_clock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_T_HR  = 3'd1,
        ST_SET_T_MIN = 3'd2,
        ST_SET_A_HR  = 3'd3,
        ST_SET_A_MIN = 3'd4
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

    if (RING_SEC < 1 || RING_SEC > 255 || SNOOZE_MIN < 1 || SNOOZE_MIN > 15) begin : g_param_check
        $error("alarm_clock_ctrl: RING_SEC or SNOOZE_MIN out of range");
    end

    state_t     r_state, w_state_nxt;
    logic       r_mode_prev, r_adv_prev, r_match_prev;
    logic       r_sec_inc, r_min_inc, r_hr_inc, r_sec_clr, r_ring, r_blink;
    logic       w_sec_inc_nxt, w_min_inc_nxt, w_hr_inc_nxt, w_sec_clr_nxt, w_ring_nxt, w_blink_nxt;
    logic [4:0] r_alarm_hr, w_alarm_hr_nxt;
    logic [5:0] r_alarm_min, w_alarm_min_nxt;
    logic [7:0] r_ring_cnt, w_ring_cnt_nxt;
    logic       w_mode_edge, w_adv_edge, w_mode_act, w_adv_act;
    logic       w_ticking, w_carry, w_match;

`ifdef ALARM_CLOCK_SNOOZE_EN
    localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
    logic [3:0] r_snz_cnt, w_snz_cnt_nxt;
    logic       r_snz_pend, w_snz_pend_nxt;
`endif

    assign w_mode_edge = bus.Mode_Btn & ~r_mode_prev;
    assign w_adv_edge  = bus.Adv_Btn & ~r_adv_prev;
    // While ringing, any button edge is consumed as a dismissal and has no other effect.
    assign w_mode_act  = w_mode_edge & ~r_ring;
    assign w_adv_act   = w_adv_edge & ~w_mode_edge & ~r_ring;
    assign w_ticking   = (r_state == ST_RUN) || (r_state == ST_SET_A_HR) || (r_state == ST_SET_A_MIN);
    assign w_carry     = bus.Tick & w_ticking & (bus.Time_Sec == 6'd59);
    assign w_match     = bus.Alarm_Sw & (r_state == ST_RUN) & (bus.Time_Hr == r_alarm_hr) &
                         (bus.Time_Min == r_alarm_min) & (bus.Time_Sec == 6'd0);

    always_ff @(posedge Clk) begin
        if (Clr) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sec_inc_nxt   = bus.Tick & w_ticking;
        w_min_inc_nxt   = w_carry;
        w_hr_inc_nxt    = w_carry & (bus.Time_Min == 6'd59);
        w_sec_clr_nxt   = 1'b0;
        w_alarm_hr_nxt  = r_alarm_hr;
        w_alarm_min_nxt = r_alarm_min;
        w_ring_nxt      = r_ring;
        w_ring_cnt_nxt  = r_ring_cnt;
        w_blink_nxt     = r_blink;
`ifdef ALARM_CLOCK_SNOOZE_EN
        w_snz_cnt_nxt   = r_snz_cnt;
        w_snz_pend_nxt  = r_snz_pend;
`endif

        if (w_mode_act) begin
            case (r_state)
                ST_RUN:       w_state_nxt = ST_SET_T_HR;
                ST_SET_T_HR:  w_state_nxt = ST_SET_T_MIN;
                ST_SET_T_MIN: w_state_nxt = ST_SET_A_HR;
                ST_SET_A_HR:  w_state_nxt = ST_SET_A_MIN;
                default:      w_state_nxt = ST_RUN;
            endcase
            w_sec_clr_nxt = (r_state == ST_SET_T_MIN);
        end else if (w_adv_act) begin
            case (r_state)
                ST_SET_T_HR:  w_hr_inc_nxt = 1'b1;
                ST_SET_T_MIN: w_min_inc_nxt = 1'b1;
                ST_SET_A_HR:  w_alarm_hr_nxt = (r_alarm_hr == 5'd23) ? 5'd0 : r_alarm_hr + 5'd1;
                ST_SET_A_MIN: w_alarm_min_nxt = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
                default:      w_hr_inc_nxt = w_hr_inc_nxt;
            endcase
        end

        // Only the rising edge of match sets Ring, so a dismissed alarm stays quiet for the rest of the second.
        if (r_ring) begin
            if (bus.Tick) w_ring_cnt_nxt = r_ring_cnt + 8'd1;
            if (!bus.Alarm_Sw || w_mode_edge || w_adv_edge || (bus.Tick && r_ring_cnt == RING_LAST))
                w_ring_nxt = 1'b0;
        end else if (w_match && !r_match_prev) begin
            w_ring_nxt     = 1'b1;
            w_ring_cnt_nxt = 8'd0;
        end

`ifdef ALARM_CLOCK_SNOOZE_EN
        // Snooze counts minutes via tick carries only; manual minute sets do not shorten it.
        if (!bus.Alarm_Sw || w_mode_edge) begin
            w_snz_pend_nxt = 1'b0;
        end else if (r_ring && w_adv_edge) begin
            w_snz_pend_nxt = 1'b1;
            w_snz_cnt_nxt  = SNOOZE_LOAD;
        end else if (r_snz_pend) begin
            if (r_snz_cnt == 4'd0) begin
                w_ring_nxt     = 1'b1;
                w_ring_cnt_nxt = 8'd0;
                w_snz_pend_nxt = 1'b0;
            end else if (w_carry) begin
                w_snz_cnt_nxt = r_snz_cnt - 4'd1;
            end
        end
`endif

        if (w_state_nxt == ST_RUN)      w_blink_nxt = 1'b0;
        else if (w_state_nxt != r_state) w_blink_nxt = 1'b1;
        else if (bus.Tick)              w_blink_nxt = ~r_blink;
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_mode_prev  <= 1'b0;
            r_adv_prev   <= 1'b0;
            r_match_prev <= 1'b0;
            r_sec_inc    <= 1'b0;
            r_min_inc    <= 1'b0;
            r_hr_inc     <= 1'b0;
            r_sec_clr    <= 1'b0;
            r_ring       <= 1'b0;
            r_blink      <= 1'b0;
            r_ring_cnt   <= 8'd0;
            r_alarm_hr   <= 5'(ALARM_HR_RST);
            r_alarm_min  <= 6'(ALARM_MIN_RST);
`ifdef ALARM_CLOCK_SNOOZE_EN
            r_snz_cnt    <= 4'd0;
            r_snz_pend   <= 1'b0;
`endif
        end else begin
            r_mode_prev  <= bus.Mode_Btn;
            r_adv_prev   <= bus.Adv_Btn;
            r_match_prev <= w_match;
            r_sec_inc    <= w_sec_inc_nxt;
            r_min_inc    <= w_min_inc_nxt;
            r_hr_inc     <= w_hr_inc_nxt;
            r_sec_clr    <= w_sec_clr_nxt;
            r_ring       <= w_ring_nxt;
            r_blink      <= w_blink_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_alarm_hr   <= w_alarm_hr_nxt;
            r_alarm_min  <= w_alarm_min_nxt;
`ifdef ALARM_CLOCK_SNOOZE_EN
            r_snz_cnt    <= w_snz_cnt_nxt;
            r_snz_pend   <= w_snz_pend_nxt;
`endif
        end
    end

    assign bus.Sec_Inc   = r_sec_inc;
    assign bus.Min_Inc   = r_min_inc;
    assign bus.Hr_Inc    = r_hr_inc;
    assign bus.Sec_Clr   = r_sec_clr;
    assign bus.Alarm_Hr  = r_alarm_hr;
    assign bus.Alarm_Min = r_alarm_min;
    assign bus.Mode      = r_state;
    assign bus.Ring      = r_ring;
    assign bus.Blink     = r_blink;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: vector table, directed corner sequences and random
// stimulus against a behavioural model of the clock's rules.
module tb_alarm_clock_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int W          = 20;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    alarm_clock_ctrl_if bus();

    alarm_clock_ctrl #(
        .RING_SEC     (RING_SEC),
        .SNOOZE_MIN   (SNOOZE_MIN),
        .ALARM_HR_RST (6),
        .ALARM_MIN_RST(0)
    ) dut (
        .Clk(clk),
        .Clr(clr),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural model: mode index, alarm time, ring/snooze bookkeeping as plain integers.
    int m_mode, m_ahr, m_amin, m_ring_ticks, m_snz_left;
    bit m_mprev, m_aprev, m_match_prev, m_ring, m_blink, m_snz_pend;
    bit m_sinc, m_minc, m_hinc, m_sclr;

    typedef struct {
        bit tick, mb, ab;
        int sec, min, hr;
        bit sinc, minc, hinc, sclr;
        int mode;
        bit blink;
        int ahr, amin;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(bit tick, bit mb, bit ab, int sec, int min, int hr,
                                bit sinc, bit minc, bit hinc, bit sclr, int mode, bit blink,
                                int ahr, int amin);
        vec_t v;
        v.tick = tick; v.mb = mb; v.ab = ab; v.sec = sec; v.min = min; v.hr = hr;
        v.sinc = sinc; v.minc = minc; v.hinc = hinc; v.sclr = sclr; v.mode = mode;
        v.blink = blink; v.ahr = ahr; v.amin = amin;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] m_pack();
        return {m_sinc, m_minc, m_hinc, m_sclr, 5'(m_ahr), 6'(m_amin), 3'(m_mode), m_ring, m_blink};
    endfunction

    task automatic m_step();
        bit me, ae, ticking, carry, match, n_ring;
        int n_mode;
        if (clr) begin
            m_mode = 0; m_ahr = 6; m_amin = 0; m_ring = 0; m_ring_ticks = 0; m_blink = 0;
            m_sinc = 0; m_minc = 0; m_hinc = 0; m_sclr = 0;
            m_mprev = 0; m_aprev = 0; m_match_prev = 0; m_snz_pend = 0; m_snz_left = 0;
        end else begin
            me      = bus.Mode_Btn && !m_mprev;
            ae      = bus.Adv_Btn && !m_aprev;
            ticking = (m_mode == 0) || (m_mode >= 3);
            carry   = bus.Tick && ticking && (bus.Time_Sec == 59);
            match   = bus.Alarm_Sw && (m_mode == 0) && (bus.Time_Hr == m_ahr) &&
                      (bus.Time_Min == m_amin) && (bus.Time_Sec == 0);
            m_sinc = bus.Tick && ticking;
            m_minc = carry;
            m_hinc = carry && (bus.Time_Min == 59);
            m_sclr = 0;
            n_mode = m_mode;
            if (me) begin
                if (!m_ring) begin
                    n_mode = (m_mode + 1) % 5;
                    m_sclr = (m_mode == 2);
                end
            end else if (ae && !m_ring) begin
                if (m_mode == 1) m_hinc = 1;
                if (m_mode == 2) m_minc = 1;
                if (m_mode == 3) m_ahr = (m_ahr + 1) % 24;
                if (m_mode == 4) m_amin = (m_amin + 1) % 60;
            end
            n_ring = m_ring;
            if (m_ring) begin
                if (bus.Tick) m_ring_ticks++;
                if (!bus.Alarm_Sw || me || ae || m_ring_ticks == RING_SEC) n_ring = 0;
            end else if (match && !m_match_prev) begin
                n_ring = 1;
                m_ring_ticks = 0;
            end
`ifdef ALARM_CLOCK_SNOOZE_EN
            if (!bus.Alarm_Sw || me) begin
                m_snz_pend = 0;
            end else if (m_ring && ae) begin
                m_snz_pend = 1;
                m_snz_left = SNOOZE_MIN;
            end else if (m_snz_pend) begin
                if (m_snz_left == 0) begin
                    n_ring = 1;
                    m_ring_ticks = 0;
                    m_snz_pend = 0;
                end else if (carry) begin
                    m_snz_left--;
                end
            end
`endif
            if (n_mode == 0)           m_blink = 0;
            else if (n_mode != m_mode) m_blink = 1;
            else if (bus.Tick)         m_blink = !m_blink;
            m_mode = n_mode;
            m_ring = n_ring;
            m_match_prev = match;
            m_mprev = bus.Mode_Btn;
            m_aprev = bus.Adv_Btn;
        end
        exp_q.push_back(m_pack());
    endtask

    // One clock: model predicts, DUT advances, every output is compared 1 ns after the edge.
    task automatic step();
        logic [W-1:0] e;
        m_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sec_inc",   int'(bus.Sec_Inc),   int'(e[19]));
        chk("min_inc",   int'(bus.Min_Inc),   int'(e[18]));
        chk("hr_inc",    int'(bus.Hr_Inc),    int'(e[17]));
        chk("sec_clr",   int'(bus.Sec_Clr),   int'(e[16]));
        chk("alarm_hr",  int'(bus.Alarm_Hr),  int'(e[15:11]));
        chk("alarm_min", int'(bus.Alarm_Min), int'(e[10:5]));
        chk("mode",      int'(bus.Mode),      int'(e[4:2]));
        chk("ring",      int'(bus.Ring),      int'(e[1]));
        chk("blink",     int'(bus.Blink),     int'(e[0]));
    endtask

    task automatic set_in(input bit tick, input bit mb, input bit ab, input bit sw,
                          input int sec, input int min, input int hr);
        bus.Tick = tick; bus.Mode_Btn = mb; bus.Adv_Btn = ab; bus.Alarm_Sw = sw;
        bus.Time_Sec = 6'(sec); bus.Time_Min = 6'(min); bus.Time_Hr = 5'(hr);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        set_in(0, 0, 0, 0, 30, 30, 12);
        step();
        step();
        clr = 1'b0;
    endtask

    task automatic press(input bit mb, input bit ab);
        bus.Mode_Btn = mb; bus.Adv_Btn = ab;
        step();
        bus.Mode_Btn = 0; bus.Adv_Btn = 0;
        step();
    endtask

    initial begin
        bit rm, ra;
        int r;
        set_in(0, 0, 0, 0, 30, 30, 12);

        // Reset state
        do_reset();
        chk("rst_mode", int'(bus.Mode), 0);
        chk("rst_ring", int'(bus.Ring), 0);
        chk("rst_alarm_hr", int'(bus.Alarm_Hr), 6);
        chk("rst_alarm_min", int'(bus.Alarm_Min), 0);

        // Vector table applied from reset with Alarm_Sw low
        vecs[0]  = mk(1,0,0, 59,59,12, 1,1,1,0, 0,0, 6,0);
        vecs[1]  = mk(0,0,0, 59,59,12, 0,0,0,0, 0,0, 6,0);
        vecs[2]  = mk(0,1,0, 59,59,12, 0,0,0,0, 1,1, 6,0);
        vecs[3]  = mk(0,0,0, 59,59,12, 0,0,0,0, 1,1, 6,0);
        vecs[4]  = mk(0,1,0, 59,59,12, 0,0,0,0, 2,1, 6,0);
        vecs[5]  = mk(1,0,0, 10,59,12, 0,0,0,0, 2,0, 6,0);
        vecs[6]  = mk(0,0,1, 59,59,12, 0,1,0,0, 2,0, 6,0);
        vecs[7]  = mk(0,1,0, 59,59,12, 0,0,0,1, 3,1, 6,0);
        vecs[8]  = mk(0,0,0, 59,59,12, 0,0,0,0, 3,1, 6,0);
        vecs[9]  = mk(0,0,1, 59,59,12, 0,0,0,0, 3,1, 7,0);
        vecs[10] = mk(0,0,0, 59,59,12, 0,0,0,0, 3,1, 7,0);
        vecs[11] = mk(0,1,1, 59,59,12, 0,0,0,0, 4,1, 7,0);
        vecs[12] = mk(0,0,0, 59,59,12, 0,0,0,0, 4,1, 7,0);
        vecs[13] = mk(0,0,1, 59,59,12, 0,0,0,0, 4,1, 7,1);
        vecs[14] = mk(1,0,0, 30,59,12, 1,0,0,0, 4,0, 7,1);
        vecs[15] = mk(0,1,0, 30,59,12, 0,0,0,0, 0,0, 7,1);
        vecs[16] = mk(0,0,0, 30,59,12, 0,0,0,0, 0,0, 7,1);
        for (int i = 0; i < 17; i++) begin
            set_in(vecs[i].tick, vecs[i].mb, vecs[i].ab, 0, vecs[i].sec, vecs[i].min, vecs[i].hr);
            step();
            chk($sformatf("tbl%0d_sec_inc", i), int'(bus.Sec_Inc), int'(vecs[i].sinc));
            chk($sformatf("tbl%0d_min_inc", i), int'(bus.Min_Inc), int'(vecs[i].minc));
            chk($sformatf("tbl%0d_hr_inc", i),  int'(bus.Hr_Inc),  int'(vecs[i].hinc));
            chk($sformatf("tbl%0d_sec_clr", i), int'(bus.Sec_Clr), int'(vecs[i].sclr));
            chk($sformatf("tbl%0d_mode", i),    int'(bus.Mode),    vecs[i].mode);
            chk($sformatf("tbl%0d_blink", i),   int'(bus.Blink),   int'(vecs[i].blink));
            chk($sformatf("tbl%0d_alarm_hr", i),  int'(bus.Alarm_Hr),  vecs[i].ahr);
            chk($sformatf("tbl%0d_alarm_min", i), int'(bus.Alarm_Min), vecs[i].amin);
        end

        // Alarm hour wraps 23 -> 0; simultaneous Mode+Adv leaves the hour alone
        do_reset();
        for (int i = 0; i < 3; i++) press(1, 0);
        chk("seq_mode3", int'(bus.Mode), 3);
        for (int i = 0; i < 17; i++) press(0, 1);
        chk("seq_alarm_hr23", int'(bus.Alarm_Hr), 23);
        press(0, 1);
        chk("seq_alarm_hr_wrap", int'(bus.Alarm_Hr), 0);
        press(1, 1);
        chk("seq_mode_wins", int'(bus.Mode), 4);
        chk("seq_adv_dropped", int'(bus.Alarm_Hr), 0);

        // Ring at 06:00:00, auto-clear after RING_SEC ticks, no retrigger while the time still matches
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 6);
        step();
        chk("ring_set", int'(bus.Ring), 1);
        for (int i = 1; i <= RING_SEC; i++) begin
            bus.Tick = 1;
            step();
            if (i == RING_SEC - 1) chk("ring_before_last_tick", int'(bus.Ring), 1);
        end
        chk("ring_auto_clear", int'(bus.Ring), 0);
        bus.Tick = 0;
        for (int i = 0; i < 5; i++) step();
        chk("ring_no_retrigger", int'(bus.Ring), 0);

        // Adv dismisses; with snooze built, five tick carries bring Ring back
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 6);
        step();
        chk("snz_ring_set", int'(bus.Ring), 1);
        press(0, 1);
        chk("snz_dismiss", int'(bus.Ring), 0);
        for (int i = 0; i < SNOOZE_MIN; i++) begin
            set_in(1, 0, 0, 1, 59, i + 1, 6);
            step();
            chk("snz_quiet", int'(bus.Ring), 0);
            bus.Tick = 0;
            step();
        end
`ifdef ALARM_CLOCK_SNOOZE_EN
        chk("snz_rering", int'(bus.Ring), 1);
`else
        chk("snz_stays_off", int'(bus.Ring), 0);
`endif
        bus.Alarm_Sw = 0;
        step();
        chk("sw_off_clears", int'(bus.Ring), 0);

        // Clr mid-ring in a set mode with a modified alarm
        do_reset();
        for (int i = 0; i < 3; i++) press(1, 0);
        press(0, 1);
        press(1, 0);
        press(0, 1);
        press(1, 0);
        chk("clr_pre_alarm_hr", int'(bus.Alarm_Hr), 7);
        chk("clr_pre_alarm_min", int'(bus.Alarm_Min), 1);
        set_in(0, 1, 0, 1, 0, 1, 7);
        step();
        chk("clr_pre_ring", int'(bus.Ring), 1);
        chk("clr_pre_mode", int'(bus.Mode), 1);
        clr = 1'b1;
        set_in(1, 1, 1, 1, 0, 1, 7);
        step();
        clr = 1'b0;
        chk("clr_mode", int'(bus.Mode), 0);
        chk("clr_ring", int'(bus.Ring), 0);
        chk("clr_alarm_hr", int'(bus.Alarm_Hr), 6);
        chk("clr_alarm_min", int'(bus.Alarm_Min), 0);
        chk("clr_sec_inc", int'(bus.Sec_Inc), 0);
        set_in(0, 0, 0, 0, 30, 30, 12);
        step();

        // Random stimulus against the model
        do_reset();
        rm = 0; ra = 0;
        for (int n = 0; n < 4000; n++) begin
            clr = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) rm = !rm;
            if ($urandom_range(0, 15) == 0) ra = !ra;
            bus.Mode_Btn = rm;
            bus.Adv_Btn  = ra;
            bus.Tick     = ($urandom_range(0, 3) == 0);
            bus.Alarm_Sw = ($urandom_range(0, 19) != 0);
            r = $urandom_range(0, 3);
            bus.Time_Sec = (r == 0) ? 6'd0 : (r == 1) ? 6'd59 : 6'($urandom_range(0, 59));
            r = $urandom_range(0, 3);
            bus.Time_Min = (r == 0) ? 6'(m_amin) : (r == 1) ? 6'd59 : 6'($urandom_range(0, 59));
            bus.Time_Hr  = ($urandom_range(0, 1) == 0) ? 5'(m_ahr) : 5'($urandom_range(0, 23));
            step();
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
